// File: rtl/instr_decode_issue.sv
// instr_decode_issue: three-cycle decode/issue of 16-bit instructions; IMM_SIGN_EXT_EN selects sign-extended immediates
module instr_decode_issue #(
  parameter int NREGS = 16,
  parameter int FLAG_W = 5,
  parameter int CARRY_BIT = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [FLAG_W-1:0] flags_in,
  output logic [3:0]        alu_op,
  output logic [3:0]        a_sel,
  output logic [3:0]        b_sel,
  output logic [15:0]       imm,
  output logic              use_imm,
  output logic [NREGS-1:0]  reg_en,
  output logic              cin,
  output logic [FLAG_W-1:0] flags_q,
  output logic              done,
  output logic              illegal,
  output logic [15:0]       retired
);
  typedef enum logic [1:0] {IDLE, DECODE, EXEC} state_t;
  state_t state, state_n;
  logic [15:0] ir;
  logic rr, busy, legal, sets_flags;
  logic [3:0] code;
  logic [15:0] imm_ext;
  assign rr = ir[15:12] == 4'h0;
  assign code = rr ? ir[7:4] : ir[15:12];
  assign legal = code inside {4'h5, 4'h9, 4'hB, 4'h1, 4'h2, 4'h3, 4'hD};
  assign sets_flags = code inside {4'h5, 4'h9, 4'hB};
  assign busy = state != IDLE;
`ifdef IMM_SIGN_EXT_EN
  assign imm_ext = {{8{ir[7]}}, ir[7:0]};
`else
  assign imm_ext = {8'h00, ir[7:0]};
`endif
  assign instr_ready = state == IDLE;
  assign alu_op = busy ? code : 4'h0;
  assign a_sel = busy ? ir[11:8] : 4'h0;
  assign b_sel = busy ? ir[3:0] : 4'h0;
  assign use_imm = busy && !rr;
  assign imm = use_imm ? imm_ext : 16'h0000;
  // an op being abandoned by reset must neither write nor retire
  assign done = state == EXEC && !reset;
  assign reg_en = (done && code != 4'hB) ? NREGS'(1) << ir[11:8] : '0;
  assign cin = flags_q[CARRY_BIT];
  // next state: accept, then either execute or drop an undefined code
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? (instr_valid ? DECODE : IDLE) :
              state == DECODE ? (legal ? EXEC : IDLE) : IDLE;
  end
  // state, instruction latch, flags, sticky illegal and retire count
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ir <= '0;
      flags_q <= '0;
      illegal <= 1'b0;
      retired <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && instr_valid) ir <= instr;
      if (state == DECODE && !legal) illegal <= 1'b1;
      if (state == EXEC) begin
        retired <= retired + 16'd1;
        if (sets_flags) flags_q <= flags_in;
      end
    end
  end
endmodule

// File: tb/tb_instr_decode_issue.sv
// tb_instr_decode_issue: directed self-checking bench for instr_decode_issue
module tb_instr_decode_issue;
  logic clk = 0, reset = 1, instr_valid = 0, instr_ready;
  logic [15:0] instr = 0, imm, retired;
  logic [4:0] flags_in = 0, flags_q;
  logic [3:0] alu_op, a_sel, b_sel;
  logic [15:0] reg_en;
  logic use_imm, cin, done, illegal;
  int checks = 0, errors = 0;
  logic d_ready, d_done, d_cin, e_ready, e_done, e_use;
  logic [15:0] d_regen, e_regen, e_imm, e_retired;
  logic [3:0] d_alu, e_alu, e_a, e_b;

  instr_decode_issue dut (
    .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .flags_in(flags_in), .alu_op(alu_op),
    .a_sel(a_sel), .b_sel(b_sel), .imm(imm), .use_imm(use_imm),
    .reg_en(reg_en), .cin(cin), .flags_q(flags_q), .done(done),
    .illegal(illegal), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [15:0] i, input logic [4:0] f, input bit stop_in_exec);
    instr = i;
    instr_valid = 1;
    flags_in = f;
    tick();
    instr_valid = 0;
    instr = 16'hFFFF;
    d_ready = instr_ready; d_done = done; d_cin = cin; d_regen = reg_en; d_alu = alu_op;
    tick();
    e_ready = instr_ready; e_done = done; e_use = use_imm; e_regen = reg_en;
    e_imm = imm; e_alu = alu_op; e_a = a_sel; e_b = b_sel; e_retired = retired;
    if (!stop_in_exec) tick();
  endtask

  initial begin
    tick();
    tick();
    reset = 0;
    chk("rst_ready", instr_ready, 1);
    chk("rst_done", done, 0);
    chk("rst_regen", reg_en, 0);
    chk("rst_flags", flags_q, 0);
    chk("rst_illegal", illegal, 0);
    chk("rst_retired", retired, 0);
    chk("rst_alu", alu_op, 0);
    issue(16'h5001, 5'b00000, 0);
    chk("addi_d_ready", d_ready, 0);
    chk("addi_d_regen", d_regen, 0);
    chk("addi_d_done", d_done, 0);
    chk("addi_d_alu", d_alu, 4'h5);
    chk("addi_e_ready", e_ready, 0);
    chk("addi_e_regen", e_regen, 16'h0001);
    chk("addi_e_use", e_use, 1);
    chk("addi_e_imm", e_imm, 16'h0001);
    chk("addi_e_alu", e_alu, 4'h5);
    chk("addi_e_done", e_done, 1);
    chk("addi_retired", retired, 1);
    chk("addi_ready_after", instr_ready, 1);
    issue(16'h0150, 5'b01000, 0);
    chk("add_a", e_a, 1);
    chk("add_b", e_b, 0);
    chk("add_regen", e_regen, 16'h0002);
    chk("add_use", e_use, 0);
    chk("add_imm", e_imm, 0);
    chk("add_flags", flags_q, 5'b01000);
    issue(16'h02D1, 5'b00000, 0);
    chk("mov_cin", d_cin, 1);
    chk("mov_alu", e_alu, 4'hD);
    chk("mov_regen", e_regen, 16'h0004);
    chk("mov_flags", flags_q, 5'b01000);
    issue(16'h0BB3, 5'b00010, 0);
    chk("cmp_regen", e_regen, 0);
    chk("cmp_done", e_done, 1);
    chk("cmp_flags", flags_q, 5'b00010);
    chk("cmp_cin", cin, 0);
    chk("cmp_retired", retired, 4);
    issue(16'h0F70, 5'b11111, 0);
    chk("ill_sticky", illegal, 1);
    chk("ill_no_done", e_done, 0);
    chk("ill_no_regen", e_regen, 0);
    chk("ill_ready", e_ready, 1);
    chk("ill_retired", retired, 4);
    chk("ill_flags", flags_q, 5'b00010);
    issue(16'h5001, 5'b11111, 0);
    chk("post_ill_done", e_done, 1);
    chk("post_ill_retired", retired, 5);
    chk("post_ill_illegal", illegal, 1);
    issue(16'h51FF, 5'b11111, 0);
`ifdef IMM_SIGN_EXT_EN
    chk("imm_ext", e_imm, 16'hFFFF);
`else
    chk("imm_ext", e_imm, 16'h00FF);
`endif
    chk("imm_regen", e_regen, 16'h0002);
    chk("imm_cin", cin, 1);
    issue(16'h5301, 5'b00000, 1);
    chk("rst_exec_regen_pre", e_regen, 16'h0008);
    reset = 1;
    #1;
    chk("rst_exec_done", done, 0);
    chk("rst_exec_regen", reg_en, 0);
    tick();
    reset = 0;
    chk("rst2_ready", instr_ready, 1);
    chk("rst2_done", done, 0);
    chk("rst2_regen", reg_en, 0);
    chk("rst2_alu", alu_op, 0);
    chk("rst2_a", a_sel, 0);
    chk("rst2_imm", imm, 0);
    chk("rst2_use", use_imm, 0);
    chk("rst2_flags", flags_q, 0);
    chk("rst2_cin", cin, 0);
    chk("rst2_illegal", illegal, 0);
    chk("rst2_retired", retired, 0);
    for (int k = 0; k < 256; k++) issue({4'h5, 4'(k), 8'(k)}, 5'(k), 0);
    chk("retired_256", retired, 16'd256);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
